// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reorder_buffer_pkg: shared widths, types and ID helpers for the ROB    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int ROB_ID_W  = ROB_IDX_W + 1;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;

  typedef logic [ROB_ID_W-1:0]  rob_id_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_ID_W-1:0]  rob_cnt_t;
  typedef logic [REG_W-1:0]     reg_pos_t;
  typedef logic [DATA_W-1:0]    data_t;

  localparam rob_id_t  ZERO_ROB   = '0;
  localparam rob_cnt_t COUNT_FULL = rob_cnt_t'(ROB_SIZE);

  // IDs are slot index + 1 so that ID 0 can mean "no producer".
  function automatic rob_idx_t id_to_idx(input rob_id_t id);
    return rob_idx_t'(id - rob_id_t'(1));
  endfunction

  function automatic rob_id_t idx_to_id(input rob_idx_t idx);
    return rob_id_t'(idx) + rob_id_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reorder_buffer_if: dispatcher / ALU / register-file signals of the ROB |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     ena_from_dsp;
  reg_pos_t rd_from_dsp;
  logic     is_jump_from_dsp;
  logic     pred_jump_from_dsp;
  rob_id_t  rob_id_to_dsp;
  logic     full_to_dsp;
  rob_id_t  Q1_from_dsp;
  rob_id_t  Q2_from_dsp;
  logic     rdy1_to_dsp;
  logic     rdy2_to_dsp;
  data_t    V1_to_dsp;
  data_t    V2_to_dsp;

  logic     valid_from_alu;
  rob_id_t  rob_id_from_alu;
  data_t    V_from_alu;
  logic     jump_from_alu;
  data_t    target_pc_from_alu;

  logic     commit_flag_to_reg;
  logic     commit_jump_flag_to_reg;
  reg_pos_t rd_to_reg;
  rob_id_t  Q_to_reg;
  data_t    V_to_reg;
  data_t    target_pc_to_if;

  modport slave (
    input  ena_from_dsp, rd_from_dsp, is_jump_from_dsp, pred_jump_from_dsp,
    input  Q1_from_dsp, Q2_from_dsp,
    input  valid_from_alu, rob_id_from_alu, V_from_alu, jump_from_alu, target_pc_from_alu,
    output rob_id_to_dsp, full_to_dsp, rdy1_to_dsp, rdy2_to_dsp, V1_to_dsp, V2_to_dsp,
    output commit_flag_to_reg, commit_jump_flag_to_reg, rd_to_reg, Q_to_reg, V_to_reg,
    output target_pc_to_if
  );

  modport master (
    output ena_from_dsp, rd_from_dsp, is_jump_from_dsp, pred_jump_from_dsp,
    output Q1_from_dsp, Q2_from_dsp,
    output valid_from_alu, rob_id_from_alu, V_from_alu, jump_from_alu, target_pc_from_alu,
    input  rob_id_to_dsp, full_to_dsp, rdy1_to_dsp, rdy2_to_dsp, V1_to_dsp, V2_to_dsp,
    input  commit_flag_to_reg, commit_jump_flag_to_reg, rd_to_reg, Q_to_reg, V_to_reg,
    input  target_pc_to_if
  );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer_lookup.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reorder_buffer_lookup: combinational ID -> (rdy, V) port, ALU bypass   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module reorder_buffer_lookup
  import reorder_buffer_pkg::*;
(
  input  rob_id_t                  q,
  input  logic  [ROB_SIZE-1:0]     busy,
  input  logic  [ROB_SIZE-1:0]     ready,
  input  data_t [ROB_SIZE-1:0]     val,
  input  logic                     alu_valid,
  input  rob_id_t                  alu_id,
  input  data_t                    alu_val,
  output logic                     rdy,
  output data_t                    v
);

  rob_idx_t w_idx;

  assign w_idx = id_to_idx(q);

  always_comb begin
    rdy = 1'b0;
    v   = '0;
    if (q != ZERO_ROB) begin
      // The same-cycle broadcast wins: the stored copy is not written until the edge.
      if (alu_valid && (alu_id == q)) begin
        rdy = 1'b1;
        v   = alu_val;
      end else if (busy[w_idx] && ready[w_idx]) begin
        rdy = 1'b1;
        v   = val[w_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reorder_buffer: circular in-order-commit ROB; lookup ports need        |
// | ROB_FWD_EN defined, otherwise they read as 0. Revision: 1.0            |
// +-----------------------------------------------------------------------+
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave bus
);

  rob_idx_t                r_head;
  rob_idx_t                r_tail;
  rob_cnt_t                r_count;
  logic     [ROB_SIZE-1:0] r_busy;
  logic     [ROB_SIZE-1:0] r_ready;
  logic     [ROB_SIZE-1:0] r_is_jump;
  logic     [ROB_SIZE-1:0] r_pred;
  logic     [ROB_SIZE-1:0] r_actual;
  reg_pos_t [ROB_SIZE-1:0] r_rd;
  data_t    [ROB_SIZE-1:0] r_val;
  data_t    [ROB_SIZE-1:0] r_tpc;

  logic     w_full;
  logic     w_alloc;
  rob_idx_t w_wb_idx;
  logic     w_wb_hit;
  logic     w_commit;
  logic     w_mispredict;

  assign w_full       = (r_count == COUNT_FULL);
  assign w_alloc      = bus.ena_from_dsp && !w_full;
  assign w_wb_idx     = id_to_idx(bus.rob_id_from_alu);
  assign w_wb_hit     = bus.valid_from_alu && (bus.rob_id_from_alu != ZERO_ROB) && r_busy[w_wb_idx];
  assign w_commit     = r_busy[r_head] && r_ready[r_head];
  assign w_mispredict = w_commit && r_is_jump[r_head] && (r_actual[r_head] != r_pred[r_head]);

  assign bus.full_to_dsp   = w_full;
  assign bus.rob_id_to_dsp = idx_to_id(r_tail);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head                      <= '0;
      r_tail                      <= '0;
      r_count                     <= '0;
      r_busy                      <= '0;
      r_ready                     <= '0;
      bus.commit_flag_to_reg      <= 1'b0;
      bus.commit_jump_flag_to_reg <= 1'b0;
      bus.rd_to_reg               <= '0;
      bus.Q_to_reg                <= ZERO_ROB;
      bus.V_to_reg                <= '0;
      bus.target_pc_to_if         <= '0;
    end else begin
      bus.commit_flag_to_reg      <= w_commit;
      bus.commit_jump_flag_to_reg <= w_mispredict;
      bus.rd_to_reg               <= w_commit ? r_rd[r_head] : '0;
      bus.Q_to_reg                <= w_commit ? idx_to_id(r_head) : ZERO_ROB;
      bus.V_to_reg                <= w_commit ? r_val[r_head] : '0;
      if (w_mispredict) begin
        bus.target_pc_to_if <= r_tpc[r_head];
        r_head              <= '0;
        r_tail              <= '0;
        r_count             <= '0;
        r_busy              <= '0;
      end else begin
        // Allocation slot is never busy, so it cannot collide with write-back or commit.
        if (w_alloc) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_wb_hit) begin
          r_ready[w_wb_idx] <= 1'b1;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; busy/ready qualify every read.
  always_ff @(posedge clk) begin
    if (w_alloc && !w_mispredict) begin
      r_rd[r_tail]      <= bus.rd_from_dsp;
      r_is_jump[r_tail] <= bus.is_jump_from_dsp;
      r_pred[r_tail]    <= bus.pred_jump_from_dsp;
    end
    if (w_wb_hit && !w_mispredict) begin
      r_val[w_wb_idx]    <= bus.V_from_alu;
      r_actual[w_wb_idx] <= bus.jump_from_alu;
      r_tpc[w_wb_idx]    <= bus.target_pc_from_alu;
    end
  end

`ifdef ROB_FWD_EN
  reorder_buffer_lookup u_lookup1 (
    .q         (bus.Q1_from_dsp),
    .busy      (r_busy),
    .ready     (r_ready),
    .val       (r_val),
    .alu_valid (bus.valid_from_alu),
    .alu_id    (bus.rob_id_from_alu),
    .alu_val   (bus.V_from_alu),
    .rdy       (bus.rdy1_to_dsp),
    .v         (bus.V1_to_dsp)
  );

  reorder_buffer_lookup u_lookup2 (
    .q         (bus.Q2_from_dsp),
    .busy      (r_busy),
    .ready     (r_ready),
    .val       (r_val),
    .alu_valid (bus.valid_from_alu),
    .alu_id    (bus.rob_id_from_alu),
    .alu_val   (bus.V_from_alu),
    .rdy       (bus.rdy2_to_dsp),
    .v         (bus.V2_to_dsp)
  );
`else
  logic w_unused_q;
  assign w_unused_q      = ^{bus.Q1_from_dsp, bus.Q2_from_dsp};
  assign bus.rdy1_to_dsp = 1'b0;
  assign bus.rdy2_to_dsp = 1'b0;
  assign bus.V1_to_dsp   = '0;
  assign bus.V2_to_dsp   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_reorder_buffer: directed stimulus with a commit scoreboard          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_reorder_buffer;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  id;
    logic [31:0] v;
    logic        jmp;
    logic [31:0] tpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

`ifdef ROB_FWD_EN
  localparam logic        FWD      = 1'b1;
`else
  localparam logic        FWD      = 1'b0;
`endif

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic jmp, input logic pred);
    bus.ena_from_dsp       = 1'b1;
    bus.rd_from_dsp        = rd;
    bus.is_jump_from_dsp   = jmp;
    bus.pred_jump_from_dsp = pred;
    step();
    bus.ena_from_dsp       = 1'b0;
  endtask

  task automatic wb(input logic [4:0] id, input logic [31:0] v, input logic act, input logic [31:0] tpc);
    bus.valid_from_alu     = 1'b1;
    bus.rob_id_from_alu    = id;
    bus.V_from_alu         = v;
    bus.jump_from_alu      = act;
    bus.target_pc_from_alu = tpc;
    step();
    bus.valid_from_alu     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] v,
                      input logic jmp, input logic [31:0] tpc);
    exp_t e;
    e.rd = rd; e.id = id; e.v = v; e.jmp = jmp; e.tpc = tpc;
    exp_q.push_back(e);
  endtask

  // Commit monitor: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (bus.commit_flag_to_reg === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_commit: got commit of ID %0d, expected no commit", bus.Q_to_reg);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_rd", 32'(bus.rd_to_reg), 32'(mon_e.rd));
        check("commit_id", 32'(bus.Q_to_reg), 32'(mon_e.id));
        check("commit_v", bus.V_to_reg, mon_e.v);
        check("commit_jump_flag", 32'(bus.commit_jump_flag_to_reg), 32'(mon_e.jmp));
        if (mon_e.jmp) check("commit_target_pc", bus.target_pc_to_if, mon_e.tpc);
      end
    end else if (bus.commit_jump_flag_to_reg !== 1'b0) begin
      n_total++;
      $display("FAIL stray_jump_flag: got jump flag %b without commit, expected 0", bus.commit_jump_flag_to_reg);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.ena_from_dsp = 1'b0; bus.rd_from_dsp = '0; bus.is_jump_from_dsp = 1'b0;
    bus.pred_jump_from_dsp = 1'b0; bus.Q1_from_dsp = '0; bus.Q2_from_dsp = '0;
    bus.valid_from_alu = 1'b0; bus.rob_id_from_alu = '0; bus.V_from_alu = '0;
    bus.jump_from_alu = 1'b0; bus.target_pc_from_alu = '0;
    do_reset();

    check("rst_commit_flag", 32'(bus.commit_flag_to_reg), 0);
    check("rst_jump_flag", 32'(bus.commit_jump_flag_to_reg), 0);
    check("rst_target_pc", bus.target_pc_to_if, 0);
    check("rst_full", 32'(bus.full_to_dsp), 0);
    check("rst_rob_id", 32'(bus.rob_id_to_dsp), 1);

    // In-order commit of out-of-order results.
    for (int k = 1; k <= 3; k++) begin
      check("alloc_id", 32'(bus.rob_id_to_dsp), k);
      alloc(5'(k), 1'b0, 1'b0);
    end
    push(5'd1, 5'd1, 32'd10, 1'b0, 0);
    push(5'd2, 5'd2, 32'd20, 1'b0, 0);
    push(5'd3, 5'd3, 32'd30, 1'b0, 0);
    wb(5'd3, 32'd30, 1'b0, 0);
    check("no_early_commit", 32'(bus.commit_flag_to_reg), 0);
    wb(5'd1, 32'd10, 1'b0, 0);
    check("wb_commit_latency", 32'(bus.commit_flag_to_reg), 0);
    wb(5'd2, 32'd20, 1'b0, 0);
    check("first_commit_strobe", 32'(bus.commit_flag_to_reg), 1);
    check("first_commit_id", 32'(bus.Q_to_reg), 1);
    step(); step(); step();
    check("drained_rob_id", 32'(bus.rob_id_to_dsp), 4);

    // Full, refused allocation, commit-while-full, wrap-around.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      check("fill_not_full", 32'(bus.full_to_dsp), 0);
      alloc(5'(k), 1'b0, 1'b0);
    end
    check("full_set", 32'(bus.full_to_dsp), 1);
    alloc(5'd31, 1'b0, 1'b0);
    check("full_refuse_id", 32'(bus.rob_id_to_dsp), 1);
    check("full_still", 32'(bus.full_to_dsp), 1);
    push(5'd1, 5'd1, 32'hAA, 1'b0, 0);
    wb(5'd1, 32'hAA, 1'b0, 0);
    alloc(5'd17, 1'b0, 1'b0);
    check("full_commit_strobe", 32'(bus.commit_flag_to_reg), 1);
    check("full_drops", 32'(bus.full_to_dsp), 0);
    check("alloc_refused_same_cycle", 32'(bus.rob_id_to_dsp), 1);
    alloc(5'd20, 1'b0, 1'b0);
    check("wrap_next_id", 32'(bus.rob_id_to_dsp), 2);
    check("wrap_full_again", 32'(bus.full_to_dsp), 1);

    // Mispredicted jump flushes younger entries.
    do_reset();
    alloc(5'd5, 1'b0, 1'b0);
    alloc(5'd0, 1'b1, 1'b0);
    alloc(5'd6, 1'b0, 1'b0);
    alloc(5'd7, 1'b0, 1'b0);
    alloc(5'd8, 1'b0, 1'b0);
    wb(5'd3, 32'h33, 1'b0, 0);
    wb(5'd4, 32'h44, 1'b0, 0);
    push(5'd5, 5'd1, 32'h11, 1'b0, 0);
    push(5'd0, 5'd2, 32'h22, 1'b1, 32'h100);
    wb(5'd1, 32'h11, 1'b0, 0);
    wb(5'd2, 32'h22, 1'b1, 32'h100);
    alloc(5'd9, 1'b0, 1'b0);
    check("flush_jump_flag", 32'(bus.commit_jump_flag_to_reg), 1);
    check("flush_target", bus.target_pc_to_if, 32'h100);
    check("flush_rob_id", 32'(bus.rob_id_to_dsp), 1);
    step();
    check("post_flush_rob_id", 32'(bus.rob_id_to_dsp), 1);
    check("post_flush_full", 32'(bus.full_to_dsp), 0);
    check("post_flush_no_commit", 32'(bus.commit_flag_to_reg), 0);
    step(); step();

    // Lookup with bypass, stored value, not-ready and non-busy IDs.
    for (int k = 1; k <= 4; k++) alloc(5'(k), 1'b0, 1'b0);
    bus.Q1_from_dsp = 5'd4;
    bus.valid_from_alu = 1'b1; bus.rob_id_from_alu = 5'd4; bus.V_from_alu = 32'hDEAD;
    bus.jump_from_alu = 1'b0; bus.target_pc_from_alu = 0;
    #1;
    check("bypass_rdy1", 32'(bus.rdy1_to_dsp), 32'(FWD));
    check("bypass_v1", bus.V1_to_dsp, FWD ? 32'hDEAD : 32'h0);
    step();
    bus.valid_from_alu = 1'b0;
    bus.Q1_from_dsp = 5'd3;
    bus.Q2_from_dsp = 5'd4;
    #1;
    check("stored_rdy2", 32'(bus.rdy2_to_dsp), 32'(FWD));
    check("stored_v2", bus.V2_to_dsp, FWD ? 32'hDEAD : 32'h0);
    check("notready_rdy1", 32'(bus.rdy1_to_dsp), 0);
    check("notready_v1", bus.V1_to_dsp, 0);
    wb(5'd7, 32'h77, 1'b0, 0);
    bus.Q1_from_dsp = 5'd7;
    #1;
    check("nonbusy_wb_rdy1", 32'(bus.rdy1_to_dsp), 0);
    check("nonbusy_wb_rob_id", 32'(bus.rob_id_to_dsp), 5);
    check("nonbusy_wb_no_commit", 32'(bus.commit_flag_to_reg), 0);

    // Mid-operation reset with five entries in flight.
    alloc(5'd9, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_commit_flag", 32'(bus.commit_flag_to_reg), 0);
    check("midrst_jump_flag", 32'(bus.commit_jump_flag_to_reg), 0);
    check("midrst_rd", 32'(bus.rd_to_reg), 0);
    check("midrst_q", 32'(bus.Q_to_reg), 0);
    check("midrst_v", bus.V_to_reg, 0);
    check("midrst_target", bus.target_pc_to_if, 0);
    check("midrst_rob_id", 32'(bus.rob_id_to_dsp), 1);
    check("midrst_full", 32'(bus.full_to_dsp), 0);
    wb(5'd1, 32'h55, 1'b0, 0);
    step(); step();

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
